// File: rtl/fifo_umbral_pkg.sv
// Shared defaults for the threshold FIFO and the control machine that drives it:
// word/pointer widths and the thresholds loaded on reset.
package fifo_umbral_pkg;

    localparam int DATA_W_DEF   = 6;
    localparam int ADDR_W_DEF   = 3;
    localparam int UMB_BAJO_RST = 1;

    // Almost-full resets one below full so it warns before fifo_full does.
    function automatic int umb_alto_rst(input int addr_w);
        return (2 ** addr_w) - 1;
    endfunction

endpackage

// File: rtl/fifo_umbral_memoria_fifo.sv
// FIFO storage: one write port and one registered read port.
// Data is read before it is written when both ports use the same address on one edge.
module memoria_fifo #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and
// a sticky overflow/underflow flag that init or reset clears.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int UMB_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [UMB_W-1:0]  umbral_alto,
    input  logic [UMB_W-1:0]  umbral_bajo,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              fifo_error,
    output logic [UMB_W-1:0]  count
);

    localparam logic [UMB_W-1:0] DEPTH_U    = UMB_W'(2 ** ADDR_W);
    localparam logic [UMB_W-1:0] ALTO_RST_U = UMB_W'(umb_alto_rst(ADDR_W));
    localparam logic [UMB_W-1:0] BAJO_RST_U = UMB_W'(UMB_BAJO_RST);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [UMB_W-1:0]  cnt;
    logic [UMB_W-1:0]  umb_alto_q;
    logic [UMB_W-1:0]  umb_bajo_q;
    logic              push_ok;
    logic              pop_ok;
    logic              err_evt;

    // A push at full is still accepted when a pop frees the slot on the same edge.
    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt != DEPTH_U) || pop_ok);
    assign err_evt = (push && !push_ok) || (pop && !pop_ok);

    memoria_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            valid_out  <= 1'b0;
            fifo_error <= 1'b0;
            umb_alto_q <= ALTO_RST_U;
            umb_bajo_q <= BAJO_RST_U;
        end else begin
            valid_out <= pop_ok;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (init) begin
                umb_alto_q <= umbral_alto;
                umb_bajo_q <= umbral_bajo;
            end
            // A fault in the init cycle must survive the clear.
            if (err_evt)
                fifo_error <= 1'b1;
            else if (init)
                fifo_error <= 1'b0;
        end
    end

    assign count        = cnt;
    assign fifo_empty   = (cnt == '0);
    assign fifo_full    = (cnt == DEPTH_U);
    assign almost_full  = (cnt >= umb_alto_q);
    assign almost_empty = (cnt <= umb_bajo_q);

endmodule
